// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller and the datapath it sequences.
// The slave modport is the controller view and the master modport is the datapath view.
interface pipeline_ctrl_if #(
    parameter int REG_W = 6,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [REG_W-1:0] id_src_a;
    logic [REG_W-1:0] id_src_b;
    logic [REG_W-1:0] ex_dest;
    logic             ex_is_load;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_load;
    logic             if_id_load;
    logic             if_id_flush;
    logic             id_ex_load;
    logic             id_ex_flush;
    logic             ex_mem_load;
    logic             mem_wb_load;
    logic             error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_src_a, id_src_b, ex_dest, ex_is_load,
               branch_taken, mem_req, mem_ready,
        input  pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
               ex_mem_load, mem_wb_load, error, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_src_a, id_src_b, ex_dest, ex_is_load,
               branch_taken, mem_req, mem_ready,
        output pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
               ex_mem_load, mem_wb_load, error, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, branch squash, memory-wait freeze, timeout trap.
// Define PIPELINE_CTRL_PERF_EN to build the stall_cycles/flush_count performance counters.
module pipeline_ctrl #(
    parameter int REG_W       = 6,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic           clock,
    input logic           reset,
    pipeline_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              branch_pending_q, branch_pending_d;
    logic              load_use;

    logic pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush;
    logic ex_mem_load, mem_wb_load, error;

    always_comb begin
        // NOTE: every signal written here is defaulted first so no latch can be inferred.
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        branch_pending_d = branch_pending_q;
        pc_load          = 1'b0;
        if_id_load       = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_load       = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_load      = 1'b0;
        mem_wb_load      = 1'b0;
        error            = 1'b0;

        load_use = bus.ex_is_load && (bus.ex_dest != {REG_W{1'b0}}) && bus.id_valid &&
                   ((bus.ex_dest == bus.id_src_a) || (bus.ex_dest == bus.id_src_b));

        case (state_q)
            S_RUN: begin
                wait_cnt_d = '0;
                if (bus.mem_req && !bus.mem_ready) begin
                    // The freeze starts here, so a branch resolved now must not be lost.
                    state_d          = S_MEM_WAIT;
                    wait_cnt_d       = WAIT_W'(1);
                    branch_pending_d = bus.branch_taken;
                end else if (bus.branch_taken) begin
                    {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_load  = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_load = 1'b1;
                    mem_wb_load = 1'b1;
                end else begin
                    {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '1;
                end
            end

            S_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = '1;
                    if (branch_pending_q || bus.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                    branch_pending_d = 1'b0;
                    wait_cnt_d       = '0;
                    state_d          = S_RUN;
                end else begin
                    branch_pending_d = branch_pending_q | bus.branch_taken;
                    if (wait_cnt_q != {WAIT_W{1'b1}}) wait_cnt_d = wait_cnt_q + 1'b1;
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)))
                        state_d = S_ERROR;
                end
            end

            S_ERROR: error = 1'b1;

            default: state_d = S_RUN;
        endcase

        // Reset dominates every output combinationally, not just from the next edge.
        if (reset) begin
            {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush} = '0;
            {ex_mem_load, mem_wb_load, error}                           = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q          <= S_RUN;
            wait_cnt_q       <= '0;
            branch_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            branch_pending_q <= branch_pending_d;
        end
    end

    assign bus.pc_load     = pc_load;
    assign bus.if_id_load  = if_id_load;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_load  = id_ex_load;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.ex_mem_load = ex_mem_load;
    assign bus.mem_wb_load = mem_wb_load;
    assign bus.error       = error;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    // if_id_flush is raised only by a taken-branch squash, never by a load-use bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_load)    stall_cycles_q <= stall_cycles_q + 1'b1;
            if (if_id_flush) flush_count_q  <= flush_count_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4; counter expectations follow
// PIPELINE_CTRL_PERF_EN (zero when the counters are compiled out).
module tb_pipeline_ctrl;
    localparam int REG_W = 6;
    localparam int CNT_W = 32;

`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Bit order: {pc, if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem, mem_wb, error}
    localparam logic [7:0] ALL_LOAD = 8'b1101_0110;
    localparam logic [7:0] BRANCH   = 8'b1111_1110;
    localparam logic [7:0] FROZEN   = 8'b0000_0000;
    localparam logic [7:0] TRAPPED  = 8'b0000_0001;
    localparam logic [7:0] LU_MASK  = 8'b1110_1111;
    localparam logic [7:0] LU_EXP   = 8'b0000_1110;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clock = ~clock;

    pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] en();
        return {bus.pc_load, bus.if_id_load, bus.if_id_flush, bus.id_ex_load,
                bus.id_ex_flush, bus.ex_mem_load, bus.mem_wb_load, bus.error};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        return PERF ? CNT_W'(n) : '0;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic set_in(input logic idv, input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                          input logic [REG_W-1:0] dest, input logic isld, input logic br,
                          input logic mreq, input logic mrdy);
        @(negedge clock);
        bus.id_valid     = idv;
        bus.id_src_a     = a;
        bus.id_src_b     = b;
        bus.ex_dest      = dest;
        bus.ex_is_load   = isld;
        bus.branch_taken = br;
        bus.mem_req      = mreq;
        bus.mem_ready    = mrdy;
        #1;
    endtask

    task automatic test_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        bus.branch_taken = 1'b1;
        bus.mem_req      = 1'b1;
        bus.mem_ready    = 1'b0;
        #1;
        if (en() !== FROZEN) begin
            errors++;
            $display("FAIL reset_outputs(%s): got %b want %b", tag, en(), FROZEN);
        end
        checks++;
        @(negedge clock);
        #1;
        if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
            errors++;
            $display("FAIL reset_counters(%s): got stall=%0d flush=%0d want 0 0",
                     tag, bus.stall_cycles, bus.flush_count);
        end
        checks++;
        exp_stall = 0;
        exp_flush = 0;
        reset = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        #1;
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL reset_release(%s): got %b want %b", tag, en(), ALL_LOAD);
        end
        checks++;
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 6'(i + 1), 6'(i + 2), 6'(i + 10), 1'b0, 1'b0, 1'b0, 1'b0);
            if (en() !== ALL_LOAD) begin
                errors++;
                $display("FAIL straight[%0d]: got %b want %b", i, en(), ALL_LOAD);
            end
            checks++;
        end
    endtask

    task automatic test_load_use();
        set_in(1'b1, 6'd3, 6'd5, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        if ((en() & LU_MASK) !== LU_EXP) begin
            errors++;
            $display("FAIL load_use_src_b: got %b want %b (masked)", en() & LU_MASK, LU_EXP);
        end
        checks++;
        exp_stall++;
        set_in(1'b1, 6'd3, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL load_use_gone: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        set_in(1'b1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL load_use_dest0: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        set_in(1'b0, 6'd7, 6'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL load_use_invalid: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        set_in(1'b1, 6'd9, 6'd1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        if ((en() & LU_MASK) !== LU_EXP) begin
            errors++;
            $display("FAIL load_use_src_a: got %b want %b (masked)", en() & LU_MASK, LU_EXP);
        end
        checks++;
        exp_stall++;
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (en() !== FROZEN) begin
                errors++;
                $display("FAIL mem_wait_frozen[%0d]: got %b want %b", i, en(), FROZEN);
            end
            checks++;
            exp_stall++;
        end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL mem_wait_release: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL mem_ready_same_cycle: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        if (bus.stall_cycles !== exp_cnt(exp_stall)) begin
            errors++;
            $display("FAIL mem_wait_stall_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt(exp_stall));
        end
        checks++;
    endtask

    task automatic test_branch_in_wait();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, (i == 1), 1'b1, 1'b0);
            if (en() !== FROZEN) begin
                errors++;
                $display("FAIL branch_wait_frozen[%0d]: got %b want %b", i, en(), FROZEN);
            end
            checks++;
            exp_stall++;
        end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (en() !== BRANCH) begin
            errors++;
            $display("FAIL branch_wait_release: got %b want %b", en(), BRANCH);
        end
        checks++;
        exp_flush++;
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL branch_pending_cleared: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        if (bus.flush_count !== exp_cnt(exp_flush)) begin
            errors++;
            $display("FAIL branch_wait_flush_cnt: got %0d want %0d", bus.flush_count, exp_cnt(exp_flush));
        end
        checks++;
    endtask

    task automatic test_branch_priority();
        set_in(1'b1, 6'd5, 6'd0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        if (en() !== BRANCH) begin
            errors++;
            $display("FAIL branch_over_load_use: got %b want %b", en(), BRANCH);
        end
        checks++;
        exp_flush++;
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (bus.flush_count !== exp_cnt(exp_flush) || bus.stall_cycles !== exp_cnt(exp_stall)) begin
            errors++;
            $display("FAIL branch_counters: got flush=%0d stall=%0d want %0d %0d", bus.flush_count,
                     bus.stall_cycles, exp_cnt(exp_flush), exp_cnt(exp_stall));
        end
        checks++;
    endtask

    task automatic test_ready_at_timeout();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            exp_stall++;
        end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL ready_wins_timeout: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (en() !== ALL_LOAD) begin
            errors++;
            $display("FAIL ready_wins_back_to_run: got %b want %b", en(), ALL_LOAD);
        end
        checks++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (en() !== FROZEN) begin
                errors++;
                $display("FAIL timeout_frozen[%0d]: got %b want %b", i, en(), FROZEN);
            end
            checks++;
            exp_stall++;
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (en() !== TRAPPED) begin
                errors++;
                $display("FAIL timeout_error[%0d]: got %b want %b", i, en(), TRAPPED);
            end
            checks++;
            if (i == 0) exp_stall++;
        end
        if (bus.stall_cycles !== exp_cnt(exp_stall)) begin
            errors++;
            $display("FAIL timeout_stall_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt(exp_stall));
        end
        checks++;
    endtask

    initial begin
        bus.id_valid     = 1'b0;
        bus.id_src_a     = '0;
        bus.id_src_b     = '0;
        bus.ex_dest      = '0;
        bus.ex_is_load   = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;

        test_reset("init");
        test_straight_line();
        test_load_use();
        test_mem_wait();
        test_branch_in_wait();
        test_branch_priority();
        test_ready_at_timeout();
        test_timeout();
        test_reset("from_error");
        test_straight_line();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
